// File: rtl/ram_uart_tx_dma_pkg.sv
// rtl/ram_uart_tx_dma_pkg.sv - shared state enum, parity codes and constants for the RAM-to-UART DMA
package uart_dma_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, FIN} dma_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [15:0] MIN_BAUD_DIV = 16'd4;
  localparam logic        IDLE_LEVEL   = 1'b1;

  function automatic logic parity_bit(input logic [1:0] mode, input logic [8:0] data);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/ram_uart_tx_dma_if.sv
// rtl/ram_uart_tx_dma_if.sv - command/status, RAM port-B and serial signals of the DMA
// Parity_Mode exists only when UART_DMA_PARITY_EN is defined.
interface ram_uart_tx_dma_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
);
  logic              Start;
  logic              Abort;
  logic [ADDR_W-1:0] Start_Addr;
  logic [LEN_W-1:0]  Send_Len;
  logic [15:0]       Baud_Div;
  logic [ADDR_W-1:0] RAM_Addr;
  logic [DATA_W-1:0] RAM_Read_Data;
  logic              Busy;
  logic              Done;
  logic [LEN_W-1:0]  Byte_Count;
  logic              uart_tx;
`ifdef UART_DMA_PARITY_EN
  logic [1:0]        Parity_Mode;
`endif

  modport slave (
`ifdef UART_DMA_PARITY_EN
    input  Parity_Mode,
`endif
    input  Start, Abort, Start_Addr, Send_Len, Baud_Div, RAM_Read_Data,
    output RAM_Addr, Busy, Done, Byte_Count, uart_tx
  );

  modport master (
`ifdef UART_DMA_PARITY_EN
    output Parity_Mode,
`endif
    output Start, Abort, Start_Addr, Send_Len, Baud_Div, RAM_Read_Data,
    input  RAM_Addr, Busy, Done, Byte_Count, uart_tx
  );

endinterface

// File: rtl/ram_uart_tx_dma_shifter.sv
// rtl/ram_uart_tx_dma_shifter.sv - UART frame serialiser with baud and bit counters
// Inserts a parity bit after the data when UART_DMA_PARITY_EN is defined and the mode asks for one.
module uart_tx_shifter
  import uart_dma_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              abort_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [15:0]       div_i,
`ifdef UART_DMA_PARITY_EN
  input  logic [1:0]        par_mode_i,
`endif
  output logic              tx_o,
  output logic              done_o
);

  localparam int FW = DATA_W + STOP_BITS + 2;

  logic [FW-1:0] sr_q, sr_d, frame;
  logic [15:0]   baud_q, baud_d;
  logic [3:0]    bit_q, bit_d, nbits;
  logic          active_q, active_d;
  logic          bit_end;

  // Frame is shifted out LSB first; the unused top slot is padded with idle level.
  always_comb begin
    frame = {1'b1, {STOP_BITS{1'b1}}, data_i, 1'b0};
    nbits = 4'(FW - 1);
`ifdef UART_DMA_PARITY_EN
    if (par_mode_i == PAR_EVEN || par_mode_i == PAR_ODD) begin
      frame = {{STOP_BITS{1'b1}}, parity_bit(par_mode_i, 9'(data_i)), data_i, 1'b0};
      nbits = 4'(FW);
    end
`endif
  end

  assign bit_end = active_q && (baud_q == div_i - 16'd1);
  assign done_o  = bit_end && (bit_q == nbits - 4'd1);
  assign tx_o    = active_q ? sr_q[0] : IDLE_LEVEL;

  always_comb begin
    active_d = active_q;
    sr_d     = sr_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    if (abort_i) begin
      active_d = 1'b0;
    end else if (load_i) begin
      active_d = 1'b1;
      sr_d     = frame;
      baud_d   = '0;
      bit_d    = '0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (done_o) begin
          active_d = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1;
          sr_d  = {1'b1, sr_q[FW-1:1]};
        end
      end else begin
        baud_d = baud_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      sr_q     <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
    end else begin
      active_q <= active_d;
      sr_q     <= sr_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
    end
  end

endmodule

// File: rtl/ram_uart_tx_dma.sv
// rtl/ram_uart_tx_dma.sv - sequences RAM port-B fetches into the UART shifter and counts characters
// Build option: UART_DMA_PARITY_EN latches Parity_Mode at Start.
module ram_uart_tx_dma
  import uart_dma_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 16,
  parameter int RAM_RD_LAT = 1,
  parameter int STOP_BITS  = 1
) (
  input logic               Clk,
  input logic               Rst,
  ram_uart_tx_dma_if.slave  bus
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [15:0]       div_q, div_d;
  logic [1:0]        wait_q, wait_d;
  logic              busy, abort_req, shift_done;
`ifdef UART_DMA_PARITY_EN
  logic [1:0]        par_q, par_d;
`endif

  assign busy      = (state_q == FETCH) || (state_q == LOAD) || (state_q == SHIFT);
  assign abort_req = busy && bus.Abort;
  assign cnt_inc   = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    wait_d  = wait_q;
`ifdef UART_DMA_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          cnt_d = '0;
          if (bus.Send_Len != '0) begin
            addr_d  = bus.Start_Addr;
            len_d   = bus.Send_Len;
            div_d   = (bus.Baud_Div < MIN_BAUD_DIV) ? MIN_BAUD_DIV : bus.Baud_Div;
            wait_d  = '0;
            state_d = FETCH;
`ifdef UART_DMA_PARITY_EN
            par_d   = bus.Parity_Mode;
`endif
          end else begin
            state_d = FIN;
          end
        end
      end
      FETCH: begin
        if (wait_q == 2'(RAM_RD_LAT - 1)) state_d = LOAD;
        else                              wait_d  = wait_q + 2'd1;
      end
      LOAD:  state_d = SHIFT;
      SHIFT: begin
        if (shift_done) begin
          cnt_d   = cnt_inc;
          addr_d  = addr_q + ADDR_W'(1);
          wait_d  = '0;
          state_d = (cnt_inc < len_q) ? FETCH : FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort freezes progress even if it coincides with the end of a stop bit.
    if (abort_req) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      div_q   <= MIN_BAUD_DIV;
      wait_q  <= '0;
`ifdef UART_DMA_PARITY_EN
      par_q   <= PAR_NONE;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      wait_q  <= wait_d;
`ifdef UART_DMA_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.RAM_Addr   = addr_q;
  assign bus.Busy       = busy;
  assign bus.Done       = (state_q == FIN);
  assign bus.Byte_Count = cnt_q;

  uart_tx_shifter #(
    .DATA_W    (DATA_W),
    .STOP_BITS (STOP_BITS)
  ) u_shifter (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .abort_i    (abort_req),
    .load_i     (state_q == LOAD),
    .data_i     (bus.RAM_Read_Data),
    .div_i      (div_q),
`ifdef UART_DMA_PARITY_EN
    .par_mode_i (par_q),
`endif
    .tx_o       (bus.uart_tx),
    .done_o     (shift_done)
  );

endmodule
